counter_checker: RTL

- Synthesizable checker that sits directly downstream of the up/down counter and consumes the same signal bundle the counter drives and produces.
- Keeps a cycle-accurate reference model of the counter and compares count_out, max_count and zero against it on every clock.
- Reports per-cycle mismatches, error statistics and a capture of the first failure, so the bench, or an on-chip debug register, can read pass/fail without parsing text logs.

---
 rtl/counter_checker.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/counter_checker.sv
// Cycle-accurate reference checker for the up/down counter: tracks the expected count and flags mismatches.
// Latency: mismatch, statistics and first-error capture update one edge after the sampled cycle; no backpressure.
module counter_checker #(
    parameter int WIDTH       = 4,
    parameter int ERR_W       = 8,
    parameter int HALT_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic             up_down,
    input  logic             ce,
    input  logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    input  logic             check_en,
    input  logic             clr_stats,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] sample_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
    output logic [2:0]       first_flags,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [ERR_W-1:0] STAT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             mismatch_q, mismatch_d;
    logic             sticky_q, sticky_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ERR_W-1:0] smp_q, smp_d;
    logic [WIDTH-1:0] fexp_q, fexp_d;
    logic [WIDTH-1:0] fact_q, fact_d;
    logic [2:0]       fflags_q, fflags_d;

    logic cnt_bad, max_bad, zero_bad, bad;
    logic sample_vld;

    // Reference model runs in every state so it stays aligned through HALTED.
    always_comb begin
        exp_d = exp_q;
        if (!load_n) begin
            exp_d = data_load;
        end else if (ce) begin
            exp_d = up_down ? exp_q + 1'b1 : exp_q - 1'b1;
        end
    end

    always_comb begin
        cnt_bad  = (count_out != exp_q);
        max_bad  = (max_count != (&exp_q));
        zero_bad = (zero != ~(|exp_q));
        bad      = cnt_bad | max_bad | zero_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:   state_d = ST_CHECK;
            ST_CHECK:  if (sample_vld && bad && (HALT_ON_ERR != 0)) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_WAIT;
        endcase
        if (clr_stats) begin
            state_d = ST_CHECK;
        end
    end

    // A clear in the same cycle wins over the sample, so the sample is simply not taken.
    always_comb begin
        sample_vld = (state_q == ST_CHECK) && check_en && !clr_stats;
        halted     = (state_q == ST_HALTED);
    end

    always_comb begin
        mismatch_d = 1'b0;
        sticky_d   = sticky_q;
        err_d      = err_q;
        smp_d      = smp_q;
        fexp_d     = fexp_q;
        fact_d     = fact_q;
        fflags_d   = fflags_q;
        if (clr_stats) begin
            sticky_d = 1'b0;
            err_d    = '0;
            smp_d    = '0;
            fexp_d   = '0;
            fact_d   = '0;
            fflags_d = '0;
        end else if (sample_vld) begin
            if (smp_q != STAT_MAX) smp_d = smp_q + 1'b1;
            if (bad) begin
                mismatch_d = 1'b1;
                sticky_d   = 1'b1;
                if (err_q != STAT_MAX) err_d = err_q + 1'b1;
                if (err_q == '0) begin
                    fexp_d   = exp_q;
                    fact_d   = count_out;
                    fflags_d = {cnt_bad, max_bad, zero_bad};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
            sticky_q   <= 1'b0;
            err_q      <= '0;
            smp_q      <= '0;
            fexp_q     <= '0;
            fact_q     <= '0;
            fflags_q   <= '0;
        end else begin
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
            sticky_q   <= sticky_d;
            err_q      <= err_d;
            smp_q      <= smp_d;
            fexp_q     <= fexp_d;
            fact_q     <= fact_d;
            fflags_q   <= fflags_d;
        end
    end

    assign mismatch     = mismatch_q;
    assign err_sticky   = sticky_q;
    assign err_count    = err_q;
    assign sample_count = smp_q;
    assign first_exp    = fexp_q;
    assign first_act    = fact_q;
    assign first_flags  = fflags_q;

endmodule
